id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 Parameter RIDX, default 5, register index width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  decode presents an instruction.
REQ-006 in_ready  output  1  stage accepts the instruction this cycle.
REQ-007 rs_idx, rt_idx, rd_idx  input  RIDX each  source and destination register indices.
REQ-008 rs_data, rt_data, imm  input  XLEN each  register-file operands and sign-extended immediate.
REQ-009 use_imm  input  1  second ALU operand is imm instead of rt.
REQ-010 sel_in  input  3  ALU operation code; wr_en_in  input  1  instruction writes rd.
REQ-011 exmem_wr_en, exmem_rd, exmem_result  input  1/RIDX/XLEN  EX/MEM forwarding source.
REQ-012 memwb_wr_en, memwb_rd, memwb_result  input  1/RIDX/XLEN  MEM/WB forwarding source.
REQ-013 stall, flush  input  1 each  hazard-unit hold and squash.
REQ-014 X, Y  output  XLEN each  registered ALU operands; sel  output  3  registered ALU op.
REQ-015 out_valid  output  1; out_ready  input  1  ALU/EX side consumes the entry.
REQ-016 out_rd  output  RIDX; out_wr_en  output  1  destination carried to EX/MEM.
REQ-017 issue_cnt  output  32  count of instructions accepted.

Function
REQ-018 Stage SHALL be a single-entry register; capture occurs when in_valid && in_ready.
REQ-019 in_ready SHALL equal !stall && !flush && (!out_valid || out_ready), combinational.
REQ-020 Capture SHALL load X, Y, sel, out_rd, out_wr_en and set out_valid=1 on the next edge (latency 1 cycle).
REQ-021 When out_valid && out_ready and no capture, out_valid SHALL clear; with simultaneous capture, new entry replaces old with no bubble.
REQ-022 While stall=1 and flush=0, all outputs SHALL hold; out_valid unchanged regardless of out_ready.
REQ-023 flush=1 SHALL clear out_valid and out_wr_en next edge, overriding stall, capture and drain; X, Y, sel are don't-care after flush.
REQ-024 Operand A source SHALL be: exmem_result if exmem_wr_en && exmem_rd==rs_idx && rs_idx!=0; else memwb_result if memwb_wr_en && memwb_rd==rs_idx && rs_idx!=0; else rs_data.
REQ-025 Operand B SHALL apply the REQ-024 rule on rt_idx/rt_data, then Y = use_imm ? imm : forwarded rt.
REQ-026 Index 0 SHALL never be forwarded; X/Y from r0 SHALL be rs_data/rt_data as presented.
REQ-027 issue_cnt SHALL increment by 1 on each capture, wrap 0xFFFFFFFF -> 0, and not count flushed-in-same-cycle attempts (in_ready=0 then).

Reset
REQ-028 rst SHALL set out_valid=0, out_wr_en=0, X=0, Y=0, sel=0, out_rd=0, issue_cnt=0 at the next edge, overriding all other inputs.
REQ-029 in_ready SHALL be 0 during rst=1; reset mid-operation SHALL drop the held entry without emitting it.

Configuration
REQ-030 Macro ID_EX_FWD_EN: defined -> forwarding per REQ-024..026; undefined -> X=rs_data, Y=use_imm?imm:rt_data, forwarding ports present but ignored.

Structure
REQ-031 Shared package risc_pkg SHALL hold XLEN, RIDX, 3-bit ALU op encodings and the op typedef used by sel.
REQ-032 Forwarding select SHALL be one sub-module fwd_mux, instantiated twice (rs, rt).

Verification
REQ-033 Reset: rst=1 one cycle with in_valid=1 -> out_valid=0, issue_cnt=0, X=Y=0.
REQ-034 Capture: rs_data=56, rt_data=7, sel_in=0, no hazards -> next cycle X=56, Y=7, sel=0, out_valid=1, issue_cnt=1.
REQ-035 Forward priority: rs_idx=3, exmem_rd=3 result=0x40, memwb_rd=3 result=0x11 -> X=0x40; exmem_wr_en=0 -> X=0x11; rs_idx=0 -> X=rs_data.
REQ-036 Backpressure: out_valid=1, out_ready=0 -> in_ready=0, X/Y hold 3 cycles; out_ready=1 with in_valid=1 -> back-to-back replace, no bubble.
REQ-037 Stall+flush: stall=1 -> hold; stall=1 and flush=1 together -> out_valid=0 next cycle, issue_cnt unchanged.
REQ-038 Wrap: issue_cnt preset via 2^32-1 captures (or force) then one capture -> issue_cnt=0; ID_EX_FWD_EN undefined rerun of REQ-035 -> X=rs_data.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared widths and ALU op encodings for the pipeline stages.
package risc_pkg;

    localparam int XLEN = 32;
    localparam int RIDX = 5;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_op_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding select: EX/MEM beats MEM/WB, r0 never forwarded.
// Forwarding is compiled in only with ID_EX_FWD_EN defined.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RIDX = 5
) (
    input  logic [RIDX-1:0] i_idx,
    input  logic [XLEN-1:0] i_data,
    input  logic            i_exmem_wr_en,
    input  logic [RIDX-1:0] i_exmem_rd,
    input  logic [XLEN-1:0] i_exmem_result,
    input  logic            i_memwb_wr_en,
    input  logic [RIDX-1:0] i_memwb_rd,
    input  logic [XLEN-1:0] i_memwb_result,
    output logic [XLEN-1:0] o_data
);

`ifdef ID_EX_FWD_EN
    logic w_nz;
    logic w_hit_exmem;
    logic w_hit_memwb;

    assign w_nz        = |i_idx;
    assign w_hit_exmem = i_exmem_wr_en && (i_exmem_rd == i_idx) && w_nz;
    assign w_hit_memwb = i_memwb_wr_en && (i_memwb_rd == i_idx) && w_nz;

    always_comb begin
        o_data = i_data;
        unique case (1'b1)
            w_hit_exmem: o_data = i_exmem_result;
            w_hit_memwb: o_data = i_memwb_result;
            default:     o_data = i_data;
        endcase
    end
`else
    logic w_unused;
    assign w_unused = ^{i_idx, i_exmem_wr_en, i_exmem_rd, i_exmem_result,
                        i_memwb_wr_en, i_memwb_rd, i_memwb_result};
    assign o_data = i_data;
`endif

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX single-entry pipeline register with operand forwarding.
// Optional macro ID_EX_FWD_EN enables forwarding in fwd_mux.
module id_ex_stage
    import risc_pkg::*;
#(
    parameter int XLEN = risc_pkg::XLEN,
    parameter int RIDX = risc_pkg::RIDX
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RIDX-1:0] rs_idx,
    input  logic [RIDX-1:0] rt_idx,
    input  logic [RIDX-1:0] rd_idx,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic [XLEN-1:0] imm,
    input  logic            use_imm,
    input  logic [2:0]      sel_in,
    input  logic            wr_en_in,
    input  logic            exmem_wr_en,
    input  logic [RIDX-1:0] exmem_rd,
    input  logic [XLEN-1:0] exmem_result,
    input  logic            memwb_wr_en,
    input  logic [RIDX-1:0] memwb_rd,
    input  logic [XLEN-1:0] memwb_result,
    input  logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] X,
    output logic [XLEN-1:0] Y,
    output alu_op_e         sel,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RIDX-1:0] out_rd,
    output logic            out_wr_en,
    output logic [31:0]     issue_cnt
);

    logic [XLEN-1:0] r_x;
    logic [XLEN-1:0] r_y;
    alu_op_e         r_sel;
    logic            r_valid;
    logic [RIDX-1:0] r_rd;
    logic            r_wr_en;
    logic [31:0]     r_issue_cnt;

    logic [XLEN-1:0] w_rs_fwd;
    logic [XLEN-1:0] w_rt_fwd;
    logic [XLEN-1:0] w_y_next;
    logic            w_in_ready;
    logic            w_cap;

    fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rs (
        .i_idx          (rs_idx),
        .i_data         (rs_data),
        .i_exmem_wr_en  (exmem_wr_en),
        .i_exmem_rd     (exmem_rd),
        .i_exmem_result (exmem_result),
        .i_memwb_wr_en  (memwb_wr_en),
        .i_memwb_rd     (memwb_rd),
        .i_memwb_result (memwb_result),
        .o_data         (w_rs_fwd)
    );

    fwd_mux #(.XLEN(XLEN), .RIDX(RIDX)) u_fwd_rt (
        .i_idx          (rt_idx),
        .i_data         (rt_data),
        .i_exmem_wr_en  (exmem_wr_en),
        .i_exmem_rd     (exmem_rd),
        .i_exmem_result (exmem_result),
        .i_memwb_wr_en  (memwb_wr_en),
        .i_memwb_rd     (memwb_rd),
        .i_memwb_result (memwb_result),
        .o_data         (w_rt_fwd)
    );

    assign w_y_next   = use_imm ? imm : w_rt_fwd;
    // Reset also blocks acceptance so nothing is counted while rst is high.
    assign w_in_ready = !rst && !stall && !flush && (!r_valid || out_ready);
    assign w_cap      = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x         <= '0;
            r_y         <= '0;
            r_sel       <= ALU_ADD;
            r_valid     <= 1'b0;
            r_rd        <= '0;
            r_wr_en     <= 1'b0;
            r_issue_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_wr_en <= 1'b0;
        end else if (w_cap) begin
            r_x         <= w_rs_fwd;
            r_y         <= w_y_next;
            r_sel       <= alu_op_e'(sel_in);
            r_valid     <= 1'b1;
            r_rd        <= rd_idx;
            r_wr_en     <= wr_en_in;
            r_issue_cnt <= r_issue_cnt + 32'd1;
        end else if (!stall && r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign in_ready  = w_in_ready;
    assign X         = r_x;
    assign Y         = r_y;
    assign sel       = r_sel;
    assign out_valid = r_valid;
    assign out_rd    = r_rd;
    assign out_wr_en = r_wr_en;
    assign issue_cnt = r_issue_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage (both ID_EX_FWD_EN builds).
module tb_id_ex_stage;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  sel;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready;
    logic [4:0]  rs_idx, rt_idx, rd_idx;
    logic [31:0] rs_data, rt_data, imm;
    logic        use_imm, wr_en_in;
    logic [2:0]  sel_in;
    logic        exmem_wr_en, memwb_wr_en;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic        stall, flush, out_ready;
    logic [31:0] X, Y;
    risc_pkg::alu_op_e sel;
    logic        out_valid, out_wr_en;
    logic [4:0]  out_rd;
    logic [31:0] issue_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] exp_cnt = 0;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .rs_idx(rs_idx), .rt_idx(rt_idx), .rd_idx(rd_idx),
        .rs_data(rs_data), .rt_data(rt_data), .imm(imm),
        .use_imm(use_imm), .sel_in(sel_in), .wr_en_in(wr_en_in),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd),
        .exmem_result(exmem_result),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd),
        .memwb_result(memwb_result),
        .stall(stall), .flush(flush),
        .X(X), .Y(Y), .sel(sel), .out_valid(out_valid),
        .out_ready(out_ready), .out_rd(out_rd), .out_wr_en(out_wr_en),
        .issue_cnt(issue_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] s, input logic [4:0] rd,
                        input logic wr);
        exp_t e;
        e.x = x; e.y = y; e.sel = s; e.rd = rd; e.wr = wr;
        sb.push_back(e);
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL %s_sb: observed empty expected entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_x"}, X, e.x);
            chk({tag, "_y"}, Y, e.y);
            chk({tag, "_sel"}, {29'd0, sel}, {29'd0, e.sel});
            chk({tag, "_rd"}, {27'd0, out_rd}, {27'd0, e.rd});
            chk({tag, "_wr"}, {31'd0, out_wr_en}, {31'd0, e.wr});
            chk({tag, "_v"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_cnt"}, issue_cnt, exp_cnt);
        end
    endtask

    task automatic instr(input logic [4:0] rs, input logic [31:0] rsd,
                         input logic [4:0] rt, input logic [31:0] rtd,
                         input logic ui, input logic [31:0] im,
                         input logic [2:0] s, input logic [4:0] rd,
                         input logic wr);
        in_valid = 1'b1;
        rs_idx = rs; rs_data = rsd; rt_idx = rt; rt_data = rtd;
        use_imm = ui; imm = im; sel_in = s; rd_idx = rd; wr_en_in = wr;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        stall = 1'b0; flush = 1'b0;
        rs_idx = 5'd1; rt_idx = 5'd2; rd_idx = 5'd3;
        rs_data = 32'h55; rt_data = 32'h66; imm = '0;
        use_imm = 1'b0; sel_in = 3'd2; wr_en_in = 1'b1;
        exmem_wr_en = 1'b0; exmem_rd = '0; exmem_result = '0;
        memwb_wr_en = 1'b0; memwb_rd = '0; memwb_result = '0;
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        step();
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_cnt", issue_cnt, 32'd0);
        chk("rst_x", X, 32'd0);
        chk("rst_y", Y, 32'd0);
        chk("rst_sel", {29'd0, sel}, 32'd0);
        rst = 1'b0;

        instr(5'd1, 32'd56, 5'd2, 32'd7, 1'b0, 32'd0, 3'd0, 5'd4, 1'b1);
        #1 chk("cap_ready", {31'd0, in_ready}, 32'd1);
        push(32'd56, 32'd7, 3'd0, 5'd4, 1'b1);
        step();
        pop_check("cap");

        instr(5'd1, 32'd99, 5'd2, 32'd98, 1'b0, 32'd0, 3'd1, 5'd5, 1'b1);
        #1 chk("bp_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_x", X, 32'd56);
            chk("bp_y", Y, 32'd7);
            chk("bp_v", {31'd0, out_valid}, 32'd1);
        end

        out_ready = 1'b1;
        instr(5'd1, 32'd11, 5'd2, 32'd22, 1'b0, 32'd0, 3'd3, 5'd6, 1'b0);
        #1 chk("b2b_ready", {31'd0, in_ready}, 32'd1);
        push(32'd11, 32'd22, 3'd3, 5'd6, 1'b0);
        step();
        pop_check("b2b");

        exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_result = 32'h40;
        memwb_wr_en = 1'b1; memwb_rd = 5'd3; memwb_result = 32'h11;
        instr(5'd3, 32'h99, 5'd0, 32'h5, 1'b0, 32'd0, 3'd4, 5'd7, 1'b1);
`ifdef ID_EX_FWD_EN
        push(32'h40, 32'h5, 3'd4, 5'd7, 1'b1);
`else
        push(32'h99, 32'h5, 3'd4, 5'd7, 1'b1);
`endif
        step();
        pop_check("fwd_exmem");

        exmem_wr_en = 1'b0;
`ifdef ID_EX_FWD_EN
        push(32'h11, 32'h5, 3'd4, 5'd7, 1'b1);
`else
        push(32'h99, 32'h5, 3'd4, 5'd7, 1'b1);
`endif
        step();
        pop_check("fwd_memwb");

        exmem_wr_en = 1'b1; exmem_rd = 5'd0; memwb_rd = 5'd0;
        instr(5'd0, 32'h99, 5'd0, 32'h77, 1'b0, 32'd0, 3'd5, 5'd8, 1'b1);
        push(32'h99, 32'h77, 3'd5, 5'd8, 1'b1);
        step();
        pop_check("fwd_r0");

        exmem_rd = 5'd6; exmem_result = 32'h40;
        instr(5'd1, 32'h1, 5'd6, 32'h66, 1'b1, 32'h123, 3'd6, 5'd9, 1'b1);
        push(32'h1, 32'h123, 3'd6, 5'd9, 1'b1);
        step();
        pop_check("imm");

        use_imm = 1'b0;
`ifdef ID_EX_FWD_EN
        push(32'h1, 32'h40, 3'd6, 5'd9, 1'b1);
`else
        push(32'h1, 32'h66, 3'd6, 5'd9, 1'b1);
`endif
        step();
        pop_check("fwd_rt");
        exmem_wr_en = 1'b0; memwb_wr_en = 1'b0;

        stall = 1'b1;
        instr(5'd1, 32'hAA, 5'd2, 32'hBB, 1'b0, 32'd0, 3'd7, 5'd10, 1'b1);
        #1 chk("stall_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("stall_x", X, 32'h1);
            chk("stall_v", {31'd0, out_valid}, 32'd1);
            chk("stall_cnt", issue_cnt, exp_cnt);
        end

        flush = 1'b1;
        step();
        chk("flush_v", {31'd0, out_valid}, 32'd0);
        chk("flush_wr", {31'd0, out_wr_en}, 32'd0);
        chk("flush_cnt", issue_cnt, exp_cnt);
        stall = 1'b0; flush = 1'b0;

        push(32'hAA, 32'hBB, 3'd7, 5'd10, 1'b1);
        step();
        pop_check("refill");
        in_valid = 1'b0;
        step();
        chk("drain_v", {31'd0, out_valid}, 32'd0);

        force dut.r_issue_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_issue_cnt;
        #1 chk("wrap_pre", issue_cnt, 32'hFFFF_FFFF);
        exp_cnt = 32'hFFFF_FFFF;
        instr(5'd2, 32'h3, 5'd3, 32'h4, 1'b0, 32'd0, 3'd1, 5'd11, 1'b0);
        push(32'h3, 32'h4, 3'd1, 5'd11, 1'b0);
        step();
        pop_check("wrap");
        chk("wrap_zero", issue_cnt, 32'd0);

        out_ready = 1'b0; rst = 1'b1;
        step();
        chk("midrst_v", {31'd0, out_valid}, 32'd0);
        chk("midrst_x", X, 32'd0);
        chk("midrst_cnt", issue_cnt, 32'd0);
        chk("midrst_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0; in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
